// File: rtl/aes_pkg.sv
// Shared constants, controller state encoding and GF(2^8) helper for the AES-128
// key schedule controller.
package aes_pkg;

  localparam int unsigned AES_NR = 10;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StExpand,
    StFinish
  } ks_state_e;

  // Multiply by x in GF(2^8), reducing by the AES polynomial on overflow.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant byte generator: restarts at 01 on load and doubles in GF(2^8) on
// each advance.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] rcon
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcon <= 8'h00;
    end else if (load) begin
      rcon <= 8'h01;
    end else if (advance) begin
      rcon <= xtime(rcon);
    end
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: sequences an external one-round-per-clock expansion
// datapath and captures all round keys into a readable store.
module aes_key_sched_ctrl #(
  parameter int unsigned AES_NR = aes_pkg::AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         key_valid,
  output logic         done,
  output logic         kx_load_enable,
  output logic [127:0] kx_key_in,
  output logic [31:0]  kx_rcon,
  input  logic [127:0] kx_key_out,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data
);
  import aes_pkg::*;

  localparam logic [3:0] LastRound = 4'(AES_NR);

  ks_state_e    state_q;
  logic [3:0]   round_q;
  logic [127:0] key_reg;
  logic [127:0] rk [AES_NR+1];
  logic [7:0]   rcon_byte;
  logic         rcon_load;
  logic         rcon_advance;

  assign rcon_load    = (state_q == StLoad);
  assign rcon_advance = (state_q == StExpand);

  aes_rcon_gen u_rcon_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (rcon_load),
    .advance (rcon_advance),
    .rcon    (rcon_byte)
  );

  assign kx_key_in = key_reg;
  assign kx_rcon   = (state_q == StExpand) ? {rcon_byte, 24'h000000} : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      round_q        <= '0;
      key_reg        <= '0;
      busy           <= 1'b0;
      key_valid      <= 1'b0;
      done           <= 1'b0;
      kx_load_enable <= 1'b0;
    end else begin
      done           <= 1'b0;
      kx_load_enable <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            key_reg        <= key_in;
            key_valid      <= 1'b0;
            busy           <= 1'b1;
            kx_load_enable <= 1'b1;
            state_q        <= StLoad;
          end
        end
        StLoad: begin
          round_q <= 4'd1;
          state_q <= StExpand;
        end
        StExpand: begin
          // Counter holds at the last round rather than wrapping.
          if (round_q == LastRound) begin
            state_q <= StFinish;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        StFinish: begin
          busy      <= 1'b0;
          key_valid <= 1'b1;
          done      <= 1'b1;
          round_q   <= '0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The datapath output lags the round counter by one, so round r stores key r-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= AES_NR; i++) begin
        rk[i] <= '0;
      end
    end else if (state_q == StExpand) begin
      rk[round_q - 4'd1] <= kx_key_out;
    end else if (state_q == StFinish) begin
      rk[AES_NR] <= kx_key_out;
    end
  end

  always_comb begin
    rk_data = '0;
    if (rk_addr <= LastRound) begin
      rk_data = rk[rk_addr];
    end
  end

endmodule
